// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- shared definitions for the memory arbiter.
//   Holds the controller state encoding, the default parameter values
//   and a helper that sizes requester-index fields.
package mem_arb_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_DEPTH   = 256;
    localparam int DEF_ADDR    = 8;
    localparam int DEF_NREQ    = 4;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Index width for n requesters; never zero so a single requester still
    // gets a legal 1-bit field.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter -- combinational round-robin selector.
//   req   : request vector, one bit per requester
//   ptr   : requester with highest priority this round
//   grant : one-hot winner (all zero when nobody requests)
//   idx   : binary index of the winner
//   any   : at least one request present
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int PW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx,
    output logic            any
);

    logic [PW:0] pos;

    // Walk ptr, ptr+1, ... wrapping at NREQ; the first requester seen wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = '0;
        for (int i = 0; i < NREQ; i++) begin
            pos = {1'b0, ptr} + (PW+1)'(i);
            if (pos >= (PW+1)'(NREQ))
                pos = pos - (PW+1)'(NREQ);
            if (!any && req[pos[PW-1:0]]) begin
                any                = 1'b1;
                grant[pos[PW-1:0]] = 1'b1;
                idx                = pos[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- round-robin arbiter giving NREQ requesters access to a
// single-port memory, one transaction at a time.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_wrbar : per-requester request and op (1 = write)
//   req_addr/req_wdata  : packed per-requester address / write data
//   req_ready           : one-hot, one-cycle completion pulse
//   req_rdata           : read data, held until the next read completes
//   req_err             : completion ended by the watchdog (with req_ready)
//   mem_*               : memory command, held stable until mem_ready
// Build option: define MEM_ARB_TIMEOUT_EN to enable the BUSY watchdog;
// otherwise BUSY waits forever and req_err is tied low.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int ADDR    = DEF_ADDR,
    parameter int NREQ    = DEF_NREQ,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_wrbar,
    input  logic [NREQ*ADDR-1:0]  req_addr,
    input  logic [NREQ*WIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      req_rdata,
    output logic                  req_err,
    output logic [ADDR-1:0]       mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic                  mem_wrbar,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    input  logic [WIDTH-1:0]      mem_rdata
);

    localparam int PW = idx_w(NREQ);

    // Out-of-range addresses are forwarded untouched; only reject
    // configurations that cannot work at all.
    if (DEPTH < 1 || TIMEOUT < 1) begin : g_bad_cfg
        $error("mem_arbiter: DEPTH and TIMEOUT must be positive");
    end

    arb_state_e state_q, state_d;

    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   g_q;
    logic [NREQ-1:0] g_oh_q;
    logic [NREQ-1:0] win_oh;
    logic [PW-1:0]   win_idx;
    logic            win_any;
    logic            timeout;
    logic            mem_done;

    logic [ADDR-1:0]  addr_arr  [NREQ];
    logic [WIDTH-1:0] wdata_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*ADDR +: ADDR];
        assign wdata_arr[i] = req_wdata[i*WIDTH +: WIDTH];
    end

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (win_oh),
        .idx   (win_idx),
        .any   (win_any)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] to_cnt;
    logic          err_q;

    // to_cnt holds the number of BUSY cycles already spent without
    // mem_ready, so the TIMEOUT-th BUSY edge is the one that gives up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt <= '0;
        else if (state_q != BUSY)
            to_cnt <= '0;
        else if (!mem_ready)
            to_cnt <= to_cnt + TW'(1);
    end

    assign timeout = (state_q == BUSY) && !mem_ready && (to_cnt == TW'(TIMEOUT - 1));

    // Raised for the RESP cycle only, alongside req_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else
            err_q <= timeout;
    end

    assign req_err = err_q;
`else
    assign timeout = 1'b0;
    assign req_err = 1'b0;
`endif

    assign mem_done = mem_ready || timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_any)  state_d = BUSY;
            BUSY:    if (mem_done) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The grant is latched in IDLE, so requests that appear or drop later
    // cannot disturb the transaction in flight. req_ready is loaded on the
    // BUSY->RESP edge so the pulse coincides with the RESP cycle and the
    // requester has dropped req_valid before IDLE samples again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            g_q       <= '0;
            g_oh_q    <= '0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wrbar <= 1'b0;
            req_ready <= '0;
            req_rdata <= '0;
        end else begin
            req_ready <= '0;
            case (state_q)
                IDLE: begin
                    if (win_any) begin
                        g_q       <= win_idx;
                        g_oh_q    <= win_oh;
                        mem_addr  <= addr_arr[win_idx];
                        mem_wdata <= wdata_arr[win_idx];
                        mem_wrbar <= req_wrbar[win_idx];
                        mem_valid <= 1'b1;
                    end
                end
                BUSY: begin
                    if (mem_done) begin
                        mem_valid <= 1'b0;
                        req_ready <= g_oh_q;
                        if (mem_ready && !mem_wrbar)
                            req_rdata <= mem_rdata;
                    end
                end
                RESP: begin
                    ptr_q <= (g_q == PW'(NREQ - 1)) ? '0 : g_q + PW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 256;
    localparam int ADDR    = 8;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid, req_wrbar, req_ready;
    logic [NREQ*ADDR-1:0]  req_addr;
    logic [NREQ*WIDTH-1:0] req_wdata;
    logic [WIDTH-1:0]      req_rdata, mem_wdata, mem_rdata;
    logic                  req_err, mem_wrbar, mem_valid, mem_ready;
    logic [ADDR-1:0]       mem_addr;

    mem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_wrbar (req_wrbar),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .req_rdata (req_rdata),
        .req_err   (req_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wrbar (mem_wrbar),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { int id; bit wr; logic [ADDR-1:0] addr; logic [WIDTH-1:0] data; } op_t;
    typedef struct { int id; bit rd; logic [WIDTH-1:0] rdata; bit err; } exp_t;
    typedef struct { int id; bit wr; logic [ADDR-1:0] addr; logic [WIDTH-1:0] wdata; int lat; logic [WIDTH-1:0] exp_rd; } vec_t;

    op_t              pend [NREQ][$];
    exp_t             sb[$];
    logic [WIDTH-1:0] tmem [DEPTH];
    logic [WIDTH-1:0] last_rd = '0;
    int               n_vec = 0;
    int               n_bad = 0;
    int               mem_lat = 0;
    bit               hang = 1'b0;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    // Requester model: holds req_valid with the head op until its own
    // req_ready pulse, then presents the next queued op.
    initial begin
        logic [NREQ-1:0] done;
        req_valid = '0; req_wrbar = '0; req_addr = '0; req_wdata = '0;
        forever begin
            @(negedge clk);
            done = req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (done[i] && pend[i].size() > 0) void'(pend[i].pop_front());
                if (pend[i].size() > 0) begin
                    req_valid[i]                 = 1'b1;
                    req_wrbar[i]                 = pend[i][0].wr;
                    req_addr[i*ADDR +: ADDR]     = pend[i][0].addr;
                    req_wdata[i*WIDTH +: WIDTH]  = pend[i][0].data;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Memory model: answers after mem_lat extra cycles unless hang is set.
    initial begin
        int cnt;
        cnt = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < DEPTH; i++) tmem[i] = '0;
        forever begin
            @(posedge clk); #1;
            mem_ready = 1'b0;
            if (mem_valid && !hang) begin
                if (cnt >= mem_lat) begin
                    mem_ready = 1'b1;
                    cnt = 0;
                    if (mem_wrbar) tmem[mem_addr] = mem_wdata;
                    else           mem_rdata = tmem[mem_addr];
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Completion monitor: every req_ready pulse must match the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (req_ready !== '0) begin
                if (sb.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_ready: got %b expected 0000", req_ready);
                end else begin
                    e = sb.pop_front();
                    if (e.rd) last_rd = e.rdata;
                    check("grant", 64'(req_ready), 64'(1) << e.id);
                    check("rdata", 64'(req_rdata), 64'(last_rd));
                    check("err", 64'(req_err), 64'(e.err));
                end
            end
        end
    end

    task automatic wait_done(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk); #1;
            if (sb.size() == 0) ok = 1'b1;
        end
        if (!ok) begin
            n_vec++; n_bad++;
            $display("FAIL %s: %0d completions outstanding, expected 0", name, sb.size());
            sb.delete();
            for (int i = 0; i < NREQ; i++) pend[i].delete();
        end
        @(negedge clk);
    endtask

    task automatic push(input int id, input bit wr, input logic [ADDR-1:0] a, input logic [WIDTH-1:0] d);
        op_t o;
        o = '{id, wr, a, d};
        pend[id].push_back(o);
    endtask

    task automatic expect_done(input int id, input bit rd, input logic [WIDTH-1:0] rdata, input bit err);
        exp_t e;
        e = '{id, rd, rdata, err};
        sb.push_back(e);
    endtask

    initial begin
        vec_t vt[11];
        int   cnt;
        bit   seen;

        rst_n = 1'b0;
        #2;
        check("rst_mem_valid", 64'(mem_valid), 0);
        check("rst_mem_addr",  64'(mem_addr), 0);
        check("rst_mem_wdata", 64'(mem_wdata), 0);
        check("rst_mem_wrbar", 64'(mem_wrbar), 0);
        check("rst_req_ready", 64'(req_ready), 0);
        check("rst_req_rdata", 64'(req_rdata), 0);
        check("rst_req_err",   64'(req_err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        //            id wr addr   wdata          lat expected rdata
        vt[0]  = '{0, 1, 8'h10, 32'hDEADBEEF, 0, 32'h0};
        vt[1]  = '{0, 0, 8'h10, 32'h0,        0, 32'hDEADBEEF};
        vt[2]  = '{1, 1, 8'h20, 32'h12345678, 1, 32'h0};
        vt[3]  = '{2, 1, 8'hFF, 32'hA5A5A5A5, 0, 32'h0};
        vt[4]  = '{3, 0, 8'h20, 32'h0,        2, 32'h12345678};
        vt[5]  = '{1, 1, 8'h00, 32'hFFFFFFFF, 0, 32'h0};
        vt[6]  = '{2, 0, 8'hFF, 32'h0,        0, 32'hA5A5A5A5};
        vt[7]  = '{3, 0, 8'h00, 32'h0,        1, 32'hFFFFFFFF};
        vt[8]  = '{0, 0, 8'h55, 32'h0,        0, 32'h0};
        vt[9]  = '{3, 1, 8'h10, 32'h00000001, 3, 32'h0};
        vt[10] = '{1, 0, 8'h10, 32'h0,        2, 32'h00000001};

        // Single transactions: issue latency, pass-through command, completion.
        for (int v = 0; v < 11; v++) begin
            mem_lat = vt[v].lat;
            expect_done(vt[v].id, !vt[v].wr, vt[v].exp_rd, 1'b0);
            push(vt[v].id, vt[v].wr, vt[v].addr, vt[v].wdata);
            @(negedge clk);
            check("issue_early", 64'(mem_valid), 0);
            @(negedge clk);
            check("issue_valid", 64'(mem_valid), 1);
            check("issue_addr",  64'(mem_addr), 64'(vt[v].addr));
            check("issue_wrbar", 64'(mem_wrbar), 64'(vt[v].wr));
            if (vt[v].wr) check("issue_wdata", 64'(mem_wdata), 64'(vt[v].wdata));
            wait_done("vector", 50);
        end

        // Memory stalls: command must hold steady, one completion afterwards.
        mem_lat = 5;
        expect_done(2, 1'b0, '0, 1'b0);
        push(2, 1'b1, 8'h33, 32'hCAFEF00D);
        repeat (2) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            check("stall_valid", 64'(mem_valid), 1);
            check("stall_addr",  64'(mem_addr), 64'h33);
            check("stall_wdata", 64'(mem_wdata), 64'hCAFEF00D);
            check("stall_ready", 64'(req_ready), 0);
            @(negedge clk);
        end
        wait_done("stall", 50);
        mem_lat = 0;

        // Reset while BUSY (ptr is 3 here): transaction abandoned silently.
        hang = 1'b1;
        push(3, 1'b1, 8'h44, 32'h87654321);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (mem_valid) seen = 1'b1;
        end
        check("busy_reached", 64'(seen), 1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_busy_mem_valid", 64'(mem_valid), 0);
        check("rst_busy_mem_addr",  64'(mem_addr), 0);
        check("rst_busy_mem_wdata", 64'(mem_wdata), 0);
        check("rst_busy_mem_wrbar", 64'(mem_wrbar), 0);
        check("rst_busy_req_ready", 64'(req_ready), 0);
        check("rst_busy_req_rdata", 64'(req_rdata), 0);
        check("rst_busy_req_err",   64'(req_err), 0);
        for (int i = 0; i < NREQ; i++) pend[i].delete();
        hang = 1'b0;
        last_rd = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // ptr back at 0, so requester 1 beats requester 3.
        expect_done(1, 1'b0, '0, 1'b0);
        expect_done(3, 1'b0, '0, 1'b0);
        push(3, 1'b1, 8'h03, 32'h33333333);
        push(1, 1'b1, 8'h01, 32'h11111111);
        wait_done("post_reset", 50);

        // All four busy, two writes each: strict rotation.
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++) begin
                expect_done(i, 1'b0, '0, 1'b0);
                push(i, 1'b1, 8'(8'h80 + r*4 + i), 32'(32'h1000 * (i + 1) + r));
            end
        wait_done("rotation", 200);

        // Drive ptr to 3, then requesters 1 and 3: order 3, 1, 3.
        expect_done(2, 1'b0, '0, 1'b0);
        push(2, 1'b1, 8'h62, 32'h22);
        wait_done("ptr_setup", 50);
        expect_done(3, 1'b0, '0, 1'b0);
        expect_done(1, 1'b0, '0, 1'b0);
        expect_done(3, 1'b0, '0, 1'b0);
        push(3, 1'b1, 8'h73, 32'h3A);
        push(3, 1'b1, 8'h74, 32'h3B);
        push(1, 1'b1, 8'h71, 32'h1A);
        wait_done("ptr_wrap", 100);

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never answers requester 0: watchdog ends it, 1 goes next.
        hang = 1'b1;
        expect_done(0, 1'b0, '0, 1'b1);
        expect_done(1, 1'b0, '0, 1'b0);
        push(0, 1'b1, 8'h90, 32'hBAD0BAD0);
        push(1, 1'b1, 8'h91, 32'h600D600D);
        cnt = 0;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (req_ready !== '0) seen = 1'b1;
            else if (mem_valid) cnt++;
        end
        hang = 1'b0;
        check("timeout_seen", 64'(seen), 1);
        check("timeout_cycles", 64'(cnt), 64'(TIMEOUT));
        wait_done("timeout", 50);
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_bad);
        $fatal(1);
    end

endmodule
